// File: rtl/msdap_pkg.sv
// msdap_pkg: constants and types shared by the MSDAP calc output path.
//   DATA_W      result width and number of bits per serial word
//   CNT_W       bit-counter width (2**CNT_W >= DATA_W)
//   ser_state_t serializer state encoding, also used by the dual-channel wrapper
package msdap_pkg;
  localparam int DATA_W = 40;
  localparam int CNT_W  = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;
endpackage

// File: rtl/calc_out_serializer_if.sv
// calc_out_serializer_if: result handoff from the calc datapath to the serializer.
//   loadValid  calc side presents a result on dataIn
//   dataIn     result word, two's complement, already shifted
//   inReady    serializer hold buffer is empty
// master = calc datapath, slave = serializer.
interface calc_out_serializer_if;
  import msdap_pkg::*;

  logic              loadValid;
  logic [DATA_W-1:0] dataIn;
  logic              inReady;

  modport master (output loadValid, output dataIn, input inReady);
  modport slave  (input loadValid, input dataIn, output inReady);
endinterface

// File: rtl/out_hold_reg.sv
// out_hold_reg: one-entry valid/ready holding register.
//   Sclk, Reset         clock, synchronous active-high reset
//   loadValid, dataIn   write side; accepted only while inReady
//   inReady             register is empty
//   take                consumer drains the held word this cycle
//   holdValid, holdData held word
module out_hold_reg #(
  parameter int W = 40
) (
  input  logic         Sclk,
  input  logic         Reset,
  input  logic         loadValid,
  input  logic [W-1:0] dataIn,
  input  logic         take,
  output logic         inReady,
  output logic         holdValid,
  output logic [W-1:0] holdData
);

  assign inReady = !holdValid;

  // A drain needs holdValid=1, a load needs holdValid=0, so they never collide;
  // a load offered in the drain cycle is refused because inReady is still low.
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      holdValid <= 1'b0;
      holdData  <= '0;
    end else if (take) begin
      holdValid <= 1'b0;
    end else if (loadValid && inReady) begin
      holdValid <= 1'b1;
      holdData  <= dataIn;
    end
  end

endmodule

// File: rtl/calc_out_serializer.sv
// calc_out_serializer: sends each calc result MSB-first on Sout, framed by OutReady,
// starting on a frame pulse. A one-entry hold buffer accepts the next result while
// the current one is shifting.
//   Sclk, Reset     clock, synchronous active-high reset
//   ld (slave)      loadValid / dataIn / inReady result handoff
//   frame           one-cycle sample-period pulse
//   Sout, OutReady  serial data and its valid strobe (registered)
//   frameOverrun    sticky: frame arrived mid-word
//   underrun        sticky: frame arrived with nothing held (only with the macro)
// Build option CALC_OUT_UNDERRUN_ZERO_EN: a frame with an empty hold buffer sends a
// word of zeros and sets underrun; without it such a frame is ignored.
//
// state | meaning
// IDLE  | no word in flight, outputs low, waiting for frame
// SHIFT | word in flight, bitCnt counts DATA_W-1 down to 0
module calc_out_serializer
  import msdap_pkg::IDLE;
  import msdap_pkg::SHIFT;
#(
  parameter int DATA_W = msdap_pkg::DATA_W,
  parameter int CNT_W  = msdap_pkg::CNT_W
) (
  input  logic                 Sclk,
  input  logic                 Reset,
  calc_out_serializer_if.slave ld,
  input  logic                 frame,
  output logic                 Sout,
  output logic                 OutReady,
  output logic                 frameOverrun
`ifdef CALC_OUT_UNDERRUN_ZERO_EN
  ,
  output logic                 underrun
`endif
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_SHIFT = SHIFT;

  logic [0:0]        state;
  logic [CNT_W-1:0]  bitCnt;
  logic [DATA_W-1:0] shiftReg;
  logic [DATA_W-1:0] holdData;
  logic [DATA_W-1:0] startWord;
  logic              holdValid;
  logic              eow;
  logic              canStart;
  logic              take;
  logic              start;

  out_hold_reg #(.W(DATA_W)) u_hold (
    .Sclk      (Sclk),
    .Reset     (Reset),
    .loadValid (ld.loadValid),
    .dataIn    (ld.dataIn),
    .take      (take),
    .inReady   (ld.inReady),
    .holdValid (holdValid),
    .holdData  (holdData)
  );

  // Last bit of the word is being registered onto Sout this cycle; a frame here
  // chains the next word with no OutReady gap.
  assign eow       = (state == S_SHIFT) && (bitCnt == '0);
  assign canStart  = frame && ((state == S_IDLE) || eow);
  assign take      = canStart && holdValid;
  assign startWord = holdValid ? holdData : '0;

`ifdef CALC_OUT_UNDERRUN_ZERO_EN
  assign start = canStart;

  always_ff @(posedge Sclk) begin
    if (Reset)
      underrun <= 1'b0;
    else if (canStart && !holdValid)
      underrun <= 1'b1;
  end
`else
  assign start = take;
`endif

  // Sout/OutReady lag shiftReg by one register so the MSB appears the edge after frame.
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state        <= S_IDLE;
      bitCnt       <= '0;
      shiftReg     <= '0;
      Sout         <= 1'b0;
      OutReady     <= 1'b0;
      frameOverrun <= 1'b0;
    end else begin
      if (frame && (state == S_SHIFT) && (bitCnt != '0))
        frameOverrun <= 1'b1;

      if (state == S_SHIFT) begin
        Sout     <= shiftReg[DATA_W-1];
        OutReady <= 1'b1;
      end else begin
        Sout     <= 1'b0;
        OutReady <= 1'b0;
      end

      if (start) begin
        state    <= S_SHIFT;
        shiftReg <= startWord;
        bitCnt   <= CNT_W'(DATA_W - 1);
      end else if (state == S_SHIFT) begin
        if (eow) begin
          state <= S_IDLE;
        end else begin
          shiftReg <= shiftReg << 1;
          bitCnt   <= bitCnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_out_serializer.sv
module tb_calc_out_serializer;
  import msdap_pkg::DATA_W;

  logic Sclk = 1'b0;
  logic Reset = 1'b1;
  logic frame = 1'b0;
  logic Sout, OutReady, frameOverrun;
`ifdef CALC_OUT_UNDERRUN_ZERO_EN
  logic underrun;
`endif

  calc_out_serializer_if ld();

  calc_out_serializer dut (
    .Sclk         (Sclk),
    .Reset        (Reset),
    .ld           (ld),
    .frame        (frame),
    .Sout         (Sout),
    .OutReady     (OutReady),
`ifdef CALC_OUT_UNDERRUN_ZERO_EN
    .underrun     (underrun),
`endif
    .frameOverrun (frameOverrun)
  );

  always #5 Sclk = ~Sclk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of bits still to appear on Sout, one popped per edge.
  // A frame starts a word only when nothing is left queued.
  bit              mq[$];
  bit              m_hv = 1'b0;
  logic [DATA_W-1:0] m_hd = '0;
  bit              m_ovr = 1'b0;
  bit              m_ur = 1'b0;
  bit              m_or = 1'b0;
  bit              m_so = 1'b0;

  task automatic tick();
    bit acc;
    @(posedge Sclk);
    if (Reset) begin
      mq.delete();
      m_hv = 1'b0; m_hd = '0; m_ovr = 1'b0; m_ur = 1'b0; m_or = 1'b0; m_so = 1'b0;
    end else begin
      acc = ld.loadValid && !m_hv;
      if (mq.size() > 0) begin
        m_or = 1'b1;
        m_so = mq.pop_front();
      end else begin
        m_or = 1'b0;
        m_so = 1'b0;
      end
      if (frame) begin
        if (mq.size() != 0)
          m_ovr = 1'b1;
        else if (m_hv) begin
          for (int i = DATA_W - 1; i >= 0; i--) mq.push_back(m_hd[i]);
          m_hv = 1'b0;
        end
`ifdef CALC_OUT_UNDERRUN_ZERO_EN
        else begin
          for (int i = 0; i < DATA_W; i++) mq.push_back(1'b0);
          m_ur = 1'b1;
        end
`endif
      end
      if (acc) begin
        m_hv = 1'b1;
        m_hd = ld.dataIn;
      end
    end
    #1;
  endtask

  task automatic load(input logic [DATA_W-1:0] w);
    ld.loadValid = 1'b1;
    ld.dataIn    = w;
    tick();
    ld.loadValid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({OutReady, Sout, ld.inReady, frameOverrun} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_state got or=%b so=%b ir=%b ovr=%b exp 0 0 1 0",
               OutReady, Sout, ld.inReady, frameOverrun);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] w = 40'h80_0000_0001;
    bit eb;
    load(w);
    pulse_frame();
    checks++;
    if (ld.inReady !== 1'b1 || OutReady !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_frame got ir=%b or=%b exp ir=1 or=0", ld.inReady, OutReady);
    end
    for (int k = 1; k <= DATA_W + 1; k++) begin
      tick();
      eb = (k == 1) || (k == DATA_W);
      checks++;
      if (k <= DATA_W && (OutReady !== 1'b1 || Sout !== eb)) begin
        errors++;
        $display("FAIL basic_bit%0d got or=%b so=%b exp or=1 so=%b", k, OutReady, Sout, eb);
      end else if (k > DATA_W && (OutReady !== 1'b0 || Sout !== 1'b0)) begin
        errors++;
        $display("FAIL basic_end got or=%b so=%b exp 0 0", OutReady, Sout);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit eo, es;
    load(40'hFF_FFFF_FFFF);
    pulse_frame();
    for (int k = 1; k <= 2 * DATA_W + 1; k++) begin
      if (k == 1) begin
        ld.loadValid = 1'b1;
        ld.dataIn    = 40'h00_0000_0000;
      end
      if (k == DATA_W) frame = 1'b1;
      tick();
      ld.loadValid = 1'b0;
      frame        = 1'b0;
      eo = (k >= 1) && (k <= 2 * DATA_W);
      es = (k >= 1) && (k <= DATA_W);
      checks++;
      if (OutReady !== eo || Sout !== es || OutReady !== m_or || Sout !== m_so) begin
        errors++;
        $display("FAIL b2b_cycle%0d got or=%b so=%b exp or=%b so=%b", k, OutReady, Sout, eo, es);
      end
    end
  endtask

  task automatic test_blocked_load();
    logic [DATA_W-1:0] w, rx;
    w = {8'($urandom), $urandom};
    rx = '0;
    load(w);
    ld.loadValid = 1'b1;
    ld.dataIn    = 40'h12_3456_789A;
    tick();
    ld.loadValid = 1'b0;
    checks++;
    if (ld.inReady !== 1'b0) begin
      errors++;
      $display("FAIL blocked_inready got %b exp 0", ld.inReady);
    end
    tick();
    // load offered in the very cycle the buffer drains must also be refused
    ld.loadValid = 1'b1;
    ld.dataIn    = 40'h12_3456_789A;
    pulse_frame();
    ld.loadValid = 1'b0;
    checks++;
    if (ld.inReady !== 1'b1) begin
      errors++;
      $display("FAIL drain_inready got %b exp 1", ld.inReady);
    end
    for (int k = 1; k <= DATA_W + 1; k++) begin
      tick();
      if (OutReady) rx = {rx[DATA_W-2:0], Sout};
      checks++;
      if (OutReady !== m_or || Sout !== m_so) begin
        errors++;
        $display("FAIL blocked_cycle%0d got or=%b so=%b exp or=%b so=%b", k, OutReady, Sout, m_or, m_so);
      end
    end
    checks++;
    if (rx !== w) begin
      errors++;
      $display("FAIL blocked_word got %h exp %h", rx, w);
    end
    pulse_frame();
    tick();
    checks++;
    if (OutReady !== 1'b0) begin
      errors++;
      $display("FAIL lost_word_sent got or=%b exp 0", OutReady);
    end
  endtask

  task automatic test_early_frame();
    logic [DATA_W-1:0] w, rx;
    w = {8'($urandom), $urandom};
    rx = '0;
    load(w);
    pulse_frame();
    for (int k = 1; k <= DATA_W + 1; k++) begin
      if (k == 10) frame = 1'b1;
      tick();
      frame = 1'b0;
      if (OutReady) rx = {rx[DATA_W-2:0], Sout};
      checks++;
      if (OutReady !== m_or || Sout !== m_so || frameOverrun !== m_ovr) begin
        errors++;
        $display("FAIL early_cycle%0d got or=%b so=%b ovr=%b exp %b %b %b",
                 k, OutReady, Sout, frameOverrun, m_or, m_so, m_ovr);
      end
    end
    checks++;
    if (rx !== w || frameOverrun !== 1'b1) begin
      errors++;
      $display("FAIL early_word got %h ovr=%b exp %h ovr=1", rx, frameOverrun, w);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (frameOverrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b exp 0", frameOverrun);
    end
  endtask

  task automatic test_reset_mid();
    load({8'($urandom), $urandom});
    pulse_frame();
    load({8'($urandom), $urandom});
    for (int k = 2; k <= 20; k++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (OutReady !== 1'b0 || Sout !== 1'b0 || ld.inReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got or=%b so=%b ir=%b exp 0 0 1", OutReady, Sout, ld.inReady);
    end
    pulse_frame();
    for (int k = 1; k <= DATA_W + 2; k++) begin
      tick();
      checks++;
      if (OutReady !== m_or || Sout !== m_so) begin
        errors++;
        $display("FAIL after_reset_cycle%0d got or=%b so=%b exp or=%b so=%b", k, OutReady, Sout, m_or, m_so);
      end
`ifndef CALC_OUT_UNDERRUN_ZERO_EN
      checks++;
      if (OutReady !== 1'b0) begin
        errors++;
        $display("FAIL empty_frame_sent cycle%0d got or=%b exp 0", k, OutReady);
      end
`endif
    end
  endtask

`ifdef CALC_OUT_UNDERRUN_ZERO_EN
  task automatic test_underrun();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    pulse_frame();
    for (int k = 1; k <= DATA_W; k++) begin
      tick();
      checks++;
      if (OutReady !== 1'b1 || Sout !== 1'b0) begin
        errors++;
        $display("FAIL underrun_bit%0d got or=%b so=%b exp 1 0", k, OutReady, Sout);
      end
    end
    checks++;
    if (underrun !== 1'b1 || m_ur !== 1'b1) begin
      errors++;
      $display("FAIL underrun_flag got %b exp 1", underrun);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    int cnt = 0;
    int period = DATA_W;
    for (int c = 0; c < 3000; c++) begin
      ld.dataIn    = {8'($urandom), $urandom};
      ld.loadValid = ld.inReady ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      cnt++;
      frame = 1'b0;
      if (cnt >= period) begin
        frame  = 1'b1;
        cnt    = 0;
        period = DATA_W + (($urandom_range(0, 7) == 0) ? -int'($urandom_range(1, 20)) : int'($urandom_range(0, 4)));
      end
      Reset = ($urandom_range(0, 799) == 0);
      tick();
      checks++;
      if (OutReady !== m_or || Sout !== m_so || ld.inReady !== !m_hv || frameOverrun !== m_ovr) begin
        errors++;
        $display("FAIL random_cycle%0d got or=%b so=%b ir=%b ovr=%b exp %b %b %b %b",
                 c, OutReady, Sout, ld.inReady, frameOverrun, m_or, m_so, !m_hv, m_ovr);
      end
    end
    ld.loadValid = 1'b0;
    frame        = 1'b0;
    Reset        = 1'b0;
  endtask

  initial begin
    ld.loadValid = 1'b0;
    ld.dataIn    = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_blocked_load();
    test_early_frame();
    test_reset_mid();
`ifdef CALC_OUT_UNDERRUN_ZERO_EN
    test_underrun();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
